// File: rtl/slot_allocator_pkg.sv
// Shared width helpers and slot id type for the slot allocator.
package slot_allocator_pkg;

  // Slot id width for an N-slot pool (at least one bit).
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Free-count width: must hold the value N itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int N_SLOTS_DEF = 8;
  localparam int ID_W_DEF    = id_w(N_SLOTS_DEF);
  localparam int CNT_W_DEF   = cnt_w(N_SLOTS_DEF);

  typedef logic [ID_W_DEF-1:0]  slot_id_t;
  typedef logic [CNT_W_DEF-1:0] slot_cnt_t;

endpackage

// File: rtl/slot_allocator_if.sv
// Allocation / release / status bundle between the allocator and its consumer.
interface slot_allocator_if
  import slot_allocator_pkg::*;
#(
  parameter int N_SLOTS = 8
);
  localparam int ID_W  = id_w(N_SLOTS);
  localparam int CNT_W = cnt_w(N_SLOTS);

  logic             i_flush;
  logic             o_alloc_valid;
  logic [ID_W-1:0]  o_alloc_id;
  logic             i_alloc_ready;
  logic             i_free_valid;
  logic [ID_W-1:0]  i_free_id;
  logic [CNT_W-1:0] o_free_count;
  logic             o_all_busy;
  logic             o_err_double_free;

  modport slave (
    input  i_flush, i_alloc_ready, i_free_valid, i_free_id,
    output o_alloc_valid, o_alloc_id, o_free_count, o_all_busy, o_err_double_free
  );

  modport master (
    output i_flush, i_alloc_ready, i_free_valid, i_free_id,
    input  o_alloc_valid, o_alloc_id, o_free_count, o_all_busy, o_err_double_free
  );
endinterface

// File: rtl/slot_allocator_ffs.sv
// Find-first-set encoder: bit N-1 is candidate 0, so the result is the
// lowest-numbered candidate whose bit is set.
module ffs_tree
  import slot_allocator_pkg::*;
#(
  parameter int N_CANDIDATES = 8
) (
  input  logic [N_CANDIDATES-1:0]         req_i,
  output logic                            valid_o,
  output logic [id_w(N_CANDIDATES)-1:0]   idx_o
);
  localparam int IDX_W = id_w(N_CANDIDATES);

  // Scan from highest candidate down so the lowest set candidate wins.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int k = N_CANDIDATES - 1; k >= 0; k--) begin
      if (req_i[N_CANDIDATES-1-k]) idx_o = IDX_W'(k);
    end
  end
endmodule

// File: rtl/slot_allocator.sv
// Registered free-slot allocator: busy bitmap, FFS-based offer of the
// lowest free slot, releases from consumers, sticky double-free flag.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int N_SLOTS = 8
) (
  input  logic            clk,
  input  logic            rstn,
  slot_allocator_if.slave bus
);
  localparam int ID_W  = id_w(N_SLOTS);
  localparam int CNT_W = cnt_w(N_SLOTS);
  localparam logic [N_SLOTS-1:0] MSB_ONE = {1'b1, {(N_SLOTS-1){1'b0}}};

  // free bitmap: slot k lives at bit N_SLOTS-1-k, 1 = free
  logic [N_SLOTS-1:0] free_q, free_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               fire;
  logic               rel_hit_free;
  logic               free_ok;
  logic               dbl_free;
  logic [N_SLOTS-1:0] fire_mask;
  logic [N_SLOTS-1:0] rel_mask;
  logic               ffs_valid;
  logic [ID_W-1:0]    ffs_idx;

  assign fire         = valid_q & bus.i_alloc_ready;
  assign fire_mask    = MSB_ONE >> id_q;
  assign rel_mask     = MSB_ONE >> bus.i_free_id;
  // The slot currently on offer is still free, so releasing it is a double free.
  assign rel_hit_free = |(free_q & rel_mask);
  assign free_ok      = bus.i_free_valid & ~rel_hit_free;
  assign dbl_free     = bus.i_free_valid &  rel_hit_free;

  // Next bitmap, count and error flag; flush overrides alloc and free.
  always_comb begin
    free_d = free_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (bus.i_flush) begin
      free_d = '1;
      cnt_d  = CNT_W'(N_SLOTS);
    end else begin
      if (fire)     free_d = free_d & ~fire_mask;
      if (free_ok)  free_d = free_d | rel_mask;
      if (dbl_free) err_d  = 1'b1;
      cnt_d = cnt_q - CNT_W'(fire) + CNT_W'(free_ok);
    end
  end

  ffs_tree #(
    .N_CANDIDATES (N_SLOTS)
  ) u_ffs (
    .req_i   (free_d),
    .valid_o (ffs_valid),
    .idx_o   (ffs_idx)
  );

  // Offer derived from the next bitmap; the id holds when nothing is free.
  always_comb begin
    valid_d = ffs_valid;
    busy_d  = ~ffs_valid;
    id_d    = ffs_valid ? ffs_idx : id_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      free_q  <= '1;
      valid_q <= 1'b0;
      id_q    <= '0;
      cnt_q   <= CNT_W'(N_SLOTS);
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      free_q  <= free_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_alloc_valid     = valid_q;
  assign bus.o_alloc_id        = id_q;
  assign bus.o_free_count      = cnt_q;
  assign bus.o_all_busy        = busy_q;
  assign bus.o_err_double_free = err_q;
endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench: directed vector table for the corner cases, then
// randomized traffic against a slot-array reference model.
module tb_slot_allocator;
  import slot_allocator_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  slot_allocator_if #(.N_SLOTS(N)) bus ();

  slot_allocator #(.N_SLOTS(N)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // reference model: per-slot free flags, outputs recomputed from them
  bit m_free[N];
  bit m_valid;
  int m_id;
  int m_count;
  bit m_err;

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_free[k] = 1'b1;
    m_valid = 1'b0;
    m_id    = 0;
    m_count = N;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input bit fl, input bit rdy, input bit fv, input int fid);
    bit nf[N];
    bit fire;
    int lowest;
    fire = m_valid && rdy;
    if (fl) begin
      for (int k = 0; k < N; k++) nf[k] = 1'b1;
    end else begin
      nf = m_free;
      if (fire) nf[m_id] = 1'b0;
      if (fv) begin
        if (m_free[fid]) m_err = 1'b1;
        else nf[fid] = 1'b1;
      end
    end
    m_free  = nf;
    m_count = 0;
    lowest  = -1;
    for (int k = N - 1; k >= 0; k--) begin
      if (m_free[k]) begin
        m_count++;
        lowest = k;
      end
    end
    m_valid = (m_count > 0);
    if (m_valid) m_id = lowest;
  endtask

  task automatic drive(input bit fl, input bit rdy, input bit fv, input int fid);
    bus.i_flush       = fl;
    bus.i_alloc_ready = rdy;
    bus.i_free_valid  = fv;
    bus.i_free_id     = slot_id_t'(fid);
    @(posedge clk);
    model_step(fl, rdy, fv, fid);
    #1;
  endtask

  typedef struct {
    bit fl; bit rdy; bit fv; int fid;
    bit ev; int eid; int ecnt; bit ebusy; bit eerr;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(bit fl, bit rdy, bit fv, int fid,
                              bit ev, int eid, int ecnt, bit ebusy, bit eerr);
    vec_t v;
    v.fl = fl; v.rdy = rdy; v.fv = fv; v.fid = fid;
    v.ev = ev; v.eid = eid; v.ecnt = ecnt; v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    bus.i_flush = 1'b0;
    bus.i_alloc_ready = 1'b0;
    bus.i_free_valid = 1'b0;
    bus.i_free_id = '0;
    model_reset();

    //              fl rdy fv fid   ev id cnt busy err
    tbl[0]  = mk(0, 0, 0, 0,  1, 0, 8, 0, 0); // first offer
    tbl[1]  = mk(0, 1, 0, 0,  1, 1, 7, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0,  1, 2, 6, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,  1, 3, 5, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0,  1, 4, 4, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0,  1, 5, 3, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0,  1, 6, 2, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0,  1, 7, 1, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0,  0, 0, 0, 1, 0); // id 7 fires, pool empty
    tbl[9]  = mk(0, 1, 0, 0,  0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 1, 3,  1, 3, 1, 0, 0); // free into full
    tbl[11] = mk(0, 1, 1, 5,  1, 5, 1, 0, 0); // fire 3 + free 5
    tbl[12] = mk(0, 0, 1, 6,  1, 5, 2, 0, 0);
    tbl[13] = mk(0, 0, 1, 7,  1, 5, 3, 0, 0); // 0-4 busy, offer 5
    tbl[14] = mk(0, 0, 1, 1,  1, 1, 4, 0, 0); // lower free replaces offer
    tbl[15] = mk(0, 1, 0, 0,  1, 5, 3, 0, 0); // fires 1
    tbl[16] = mk(0, 1, 0, 0,  1, 6, 2, 0, 0); // fires 5
    tbl[17] = mk(0, 1, 0, 0,  1, 7, 1, 0, 0);
    tbl[18] = mk(0, 1, 1, 3,  1, 3, 1, 0, 0); // only 3 free
    tbl[19] = mk(0, 1, 1, 6,  1, 6, 1, 0, 0); // fire 3 + free 6
    tbl[20] = mk(0, 0, 1, 2,  1, 2, 2, 0, 0);
    tbl[21] = mk(0, 0, 1, 2,  1, 2, 2, 0, 1); // double free of 2
    tbl[22] = mk(0, 1, 0, 0,  1, 6, 1, 0, 1);
    tbl[23] = mk(0, 1, 1, 6,  0, 0, 0, 1, 1); // fire 6 + free of offered 6
    tbl[24] = mk(0, 0, 1, 0,  1, 0, 1, 0, 1);
    tbl[25] = mk(1, 1, 1, 4,  1, 0, 8, 0, 1); // flush wins

    // reset values while rstn low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.o_alloc_valid), 0);
    chk("rst_id",    int'(bus.o_alloc_id), 0);
    chk("rst_count", int'(bus.o_free_count), N);
    chk("rst_busy",  int'(bus.o_all_busy), 0);
    chk("rst_err",   int'(bus.o_err_double_free), 0);
    rstn = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].fl, tbl[i].rdy, tbl[i].fv, tbl[i].fid);
      chk($sformatf("vec%0d_valid", i), int'(bus.o_alloc_valid), int'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("vec%0d_id", i), int'(bus.o_alloc_id), tbl[i].eid);
      chk($sformatf("vec%0d_count", i), int'(bus.o_free_count), tbl[i].ecnt);
      chk($sformatf("vec%0d_busy", i), int'(bus.o_all_busy), int'(tbl[i].ebusy));
      chk($sformatf("vec%0d_err", i), int'(bus.o_err_double_free), int'(tbl[i].eerr));
    end

    // one more fire, then asynchronous reset between edges
    drive(0, 1, 0, 0);
    chk("pre_arst_count", int'(bus.o_free_count), 7);
    bus.i_alloc_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", int'(bus.o_alloc_valid), 0);
    chk("arst_count", int'(bus.o_free_count), N);
    chk("arst_err",   int'(bus.o_err_double_free), 0);
    chk("arst_busy",  int'(bus.o_all_busy), 0);
    chk("arst_id",    int'(bus.o_alloc_id), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();

    // randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      bit fl, rdy, fv;
      int fid;
      fl  = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 99) < ((c / 250) % 2 == 0 ? 70 : 30));
      fv  = ($urandom_range(0, 99) < 50);
      fid = $urandom_range(0, N - 1);
      drive(fl, rdy, fv, fid);
      chk("rnd_valid", int'(bus.o_alloc_valid), int'(m_valid));
      if (m_valid) chk("rnd_id", int'(bus.o_alloc_id), m_id);
      chk("rnd_count", int'(bus.o_free_count), m_count);
      chk("rnd_busy",  int'(bus.o_all_busy), int'(!m_valid));
      chk("rnd_err",   int'(bus.o_err_double_free), int'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
